// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte buffer with FWFT read port and drop tracking
//
// Purpose: buffers completed UART frames (data byte + framing-error flag) written
// by the RX controller and hands them to a consumer through a first-word-fall-through
// valid/ready port. Because the serial line cannot be back-pressured, frames that
// arrive while the buffer is full are dropped and counted.
//
// Ports:
//   clock        - system clock, all state updates on rising edge
//   reset        - synchronous active-high clear of pointers, count and drop state
//   wr_valid     - one-cycle strobe: frame complete
//   wr_data      - received byte, sampled with wr_valid
//   wr_frame_err - stop bit was low for this frame, sampled with wr_valid
//   rd_data      - byte at head of buffer
//   rd_frame_err - framing-error flag stored with head byte
//   rd_valid     - buffer not empty
//   rd_ready     - consumer accepts head (pop when rd_valid & rd_ready)
//   count        - occupied entries, 0..DEPTH
//   full         - count == DEPTH
//   overflow     - sticky: at least one frame dropped since last clear
//   ovf_clr      - clears overflow and drop_count
//   drop_count   - saturating count of dropped frames

module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int DROP_W     = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       wr_frame_err,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_frame_err,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + 1;

  // Each entry is {frame_err, data}.
  logic [EW-1:0]     mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              empty;
  logic              is_full;
  logic              pop;
  logic              push;
  logic              drop;

  assign empty   = (count_q == '0);
  assign is_full = (count_q == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full buffer still accepts a write
  // when the consumer is reading.
  assign pop  = !empty && rd_ready;
  assign push = wr_valid && (!is_full || pop);
  assign drop = wr_valid && is_full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins and restarts the count at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr) begin
        drop_d = DROP_W'(1);
      end else if (drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is never cleared; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= {wr_frame_err, wr_data};
    end
  end

  assign rd_data      = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign rd_frame_err = mem_q[rd_ptr_q][DATA_WIDTH];
  assign rd_valid     = !empty;
  assign count        = count_q;
  assign full         = is_full;
  assign overflow     = overflow_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model

module tb_uart_rx_fifo;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int DROP_W  = 8;
  localparam int DROPMAX = (1 << DROP_W) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_frame_err;
  logic [DW-1:0] rd_data;
  logic          rd_frame_err;
  logic          rd_valid;
  logic          rd_ready;
  logic [4:0]    count;
  logic          full;
  logic          overflow;
  logic          ovf_clr;
  logic [DROP_W-1:0] drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {err, data} entries plus drop bookkeeping.
  logic [DW:0] mq[$];
  logic        m_ovf;
  int          m_drops;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_frame_err(wr_frame_err), .rd_data(rd_data), .rd_frame_err(rd_frame_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count), .full(full),
    .overflow(overflow), .ovf_clr(ovf_clr), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, advance the model across the rising edge, and
  // return at the following falling edge with outputs settled.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic we,
                      input logic rr, input logic clr, input logic rst);
    int  sz;
    bit  pop;
    wr_valid = wv; wr_data = wd; wr_frame_err = we;
    rd_ready = rr; ovf_clr = clr; reset = rst;
    @(posedge clock);
    sz  = mq.size();
    pop = (sz != 0) && rr;
    if (rst) begin
      mq.delete(); m_ovf = 1'b0; m_drops = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (wv && (sz < DEPTH || pop)) begin
        mq.push_back({we, wd});
        if (clr) begin m_ovf = 1'b0; m_drops = 0; end
      end else if (wv) begin
        m_ovf   = 1'b1;
        m_drops = clr ? 1 : (m_drops < DROPMAX ? m_drops + 1 : DROPMAX);
      end else if (clr) begin
        m_ovf = 1'b0; m_drops = 0;
      end
    end
    @(negedge clock);
    wr_valid = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b exp 0", rd_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got %0d exp 0", drop_count); end
  endtask

  task automatic test_single();
    wr_valid = 1'b1; wr_data = 8'h55; wr_frame_err = 1'b0; #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL no_bypass_rd_valid got %0b exp 0", rd_valid); end
    step(1, 8'h55, 0, 0, 0, 0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_rd_valid got %0b exp 1", rd_valid); end
    checks++; if (rd_data !== mq[0][DW-1:0]) begin errors++; $display("FAIL single_rd_data got %0h exp %0h", rd_data, mq[0][DW-1:0]); end
    checks++; if (count !== 5'(mq.size())) begin errors++; $display("FAIL single_count got %0d exp %0d", count, mq.size()); end
    step(0, 8'h00, 0, 1, 0, 0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop_rd_valid got %0b exp 0", rd_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d exp 0", count); end
    step(0, 8'h00, 0, 1, 0, 0);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL empty_pop_count got %0d exp 0", count); end
  endtask

  task automatic test_fill_drain();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0, 0);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full rep%0d got %0b exp 1", rep, full); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count rep%0d got %0d exp 16", rep, count); end
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== mq[0][DW-1:0] || rd_data !== 8'(i)) begin
          errors++; $display("FAIL drain_data rep%0d idx%0d got %0h/%0b exp %0h", rep, i, rd_data, rd_valid, i);
        end
        step(0, 8'h00, 0, 1, 0, 0);
      end
      checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL drain_empty rep%0d got valid %0b count %0d exp 0", rep, rd_valid, count); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0, 0);
    step(1, 8'hBB, 0, 0, 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    checks++; if (drop_count !== 8'(m_drops) || m_drops != 2) begin errors++; $display("FAIL ovf_drop_count got %0d exp 2", drop_count); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
    step(0, 8'h00, 0, 0, 1, 0);
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL ovf_clr got %0b/%0d exp 0/0", overflow, drop_count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL ovf_contents idx%0d got %0h exp %0h", i, rd_data, i); end
      step(0, 8'h00, 0, 1, 0, 0);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0);
    step(1, 8'h77, 0, 1, 0, 0);
    checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL pushpop_count got %0d exp 16", count); end
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL pushpop_nodrop got %0b/%0d exp 0/0", overflow, drop_count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd_data !== ((i == DEPTH-1) ? 8'h77 : 8'(8'h41 + i))) begin
        errors++; $display("FAIL pushpop_order idx%0d got %0h exp %0h", i, rd_data, mq[0][DW-1:0]);
      end
      step(0, 8'h00, 0, 1, 0, 0);
    end
  endtask

  task automatic test_frame_err();
    step(1, 8'h3C, 1, 0, 0, 0);
    step(1, 8'h3D, 0, 0, 0, 0);
    checks++; if (rd_data !== 8'h3C || rd_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_first got %0h/%0b exp 3c/1", rd_data, rd_frame_err); end
    step(0, 8'h00, 0, 1, 0, 0);
    checks++; if (rd_data !== 8'h3D || rd_frame_err !== 1'b0) begin errors++; $display("FAIL ferr_second got %0h/%0b exp 3d/0", rd_data, rd_frame_err); end
    step(0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 8'($urandom), 0, 0, 0, 0);
    checks++; if (drop_count !== 8'd255 || overflow !== 1'b1) begin errors++; $display("FAIL sat_drop_count got %0d/%0b exp 255/1", drop_count, overflow); end
    step(1, 8'hEE, 0, 0, 1, 0);
    checks++; if (drop_count !== 8'd1 || overflow !== 1'b1) begin errors++; $display("FAIL clr_with_drop got %0d/%0b exp 1/1", drop_count, overflow); end
    step(0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0, 0, 0, 0);
    step(1, 8'hFF, 0, 1, 0, 1);
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midreset got count %0d valid %0b ovf %0b exp 0/0/0", count, rd_valid, overflow); end
    step(1, 8'hC3, 1, 0, 0, 0);
    checks++; if (count !== 5'd1 || rd_data !== 8'hC3 || rd_frame_err !== 1'b1) begin errors++; $display("FAIL postreset got count %0d data %0h err %0b exp 1/c3/1", count, rd_data, rd_frame_err); end
    step(0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    int wp, rp;
    for (int i = 0; i < 3000; i++) begin
      wp = (i < 1500) ? 80 : 40;
      rp = (i < 1500) ? 30 : 75;
      step($urandom_range(0, 99) < wp, 8'($urandom), 1'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 39) == 0, $urandom_range(0, 599) == 0);
      checks++;
      if (count !== 5'(mq.size()) || rd_valid !== (mq.size() != 0) || full !== (mq.size() == DEPTH) ||
          overflow !== m_ovf || drop_count !== 8'(m_drops) ||
          (mq.size() != 0 && {rd_frame_err, rd_data} !== mq[0])) begin
        errors++;
        $display("FAIL random cyc%0d got cnt %0d ovf %0b drops %0d head %0h exp cnt %0d ovf %0b drops %0d head %0h",
                 i, count, overflow, drop_count, {rd_frame_err, rd_data}, mq.size(), m_ovf, m_drops,
                 (mq.size() != 0) ? mq[0] : 9'h0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_frame_err = 1'b0;
    rd_ready = 1'b0; ovf_clr = 1'b0;
    m_ovf = 1'b0; m_drops = 0;
    @(negedge clock);
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_frame_err();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
